// File: rtl/ri_ctrl_unit.sv
// ri_ctrl_unit: multi-cycle fetch/decode/control stage of the RICPU.
// Holds PC and IR, fetches from the instruction ROM, decodes R-type and
// I-type ALU instructions and drives GPR addresses, write strobe, operand
// select flags and the ALU opcode. One instruction per four cycles
// (IF -> ID -> EX -> WB). An undecodable instruction halts the unit in ID.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   Inst_Addr  [31:0] out current PC (byte address) to the instruction ROM
//   Inst_Data  [31:0] in  ROM word at Inst_Addr, sampled at IF exit only
//   R_Addr_A/B [4:0]  out rs / rt fields of IR
//   W_Addr     [4:0]  out destination register (rt or rd per rd_rt_s)
//   Write_Reg         out register-file write strobe, high in WB
//   rd_rt_s           out 1 = destination is rt
//   rt_imm_s          out 1 = ALU operand B is Imm32
//   imm_s             out 1 = sign-extend imm16, 0 = zero-extend
//   Imm32      [31:0] out extended immediate
//   ALU_OP     [2:0]  out ALU opcode
//   State      [1:0]  out current FSM state (debug)
//   Illegal_Inst      out sticky undecodable-instruction flag
module ri_ctrl_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Inst_Addr,
    input  logic [31:0] Inst_Data,
    output logic [4:0]  R_Addr_A,
    output logic [4:0]  R_Addr_B,
    output logic [4:0]  W_Addr,
    output logic        Write_Reg,
    output logic        rd_rt_s,
    output logic        rt_imm_s,
    output logic        imm_s,
    output logic [31:0] Imm32,
    output logic [2:0]  ALU_OP,
    output logic [1:0]  State,
    output logic        Illegal_Inst
);

    typedef enum logic [1:0] {
        S_IF = 2'b00,
        S_ID = 2'b01,
        S_EX = 2'b10,
        S_WB = 2'b11
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLLV = 3'b111;

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] ir_q,        ir_d;
    logic        rd_rt_s_q,   rd_rt_s_d;
    logic        rt_imm_s_q,  rt_imm_s_d;
    logic        imm_s_q,     imm_s_d;
    logic [2:0]  alu_op_q,    alu_op_d;
    logic        illegal_q,   illegal_d;
    logic        write_reg_q, write_reg_d;

    logic        dec_legal;
    logic [2:0]  dec_op;
    logic        dec_rd_rt_s;
    logic        dec_rt_imm_s;
    logic        dec_imm_s;

    // Instruction decoder working on the held IR
    always_comb begin
        dec_legal    = 1'b0;
        dec_op       = OP_ADD;
        dec_rd_rt_s  = 1'b0;
        dec_rt_imm_s = 1'b0;
        dec_imm_s    = 1'b0;
        if (ir_q[31:26] == 6'b000000) begin
            dec_legal = 1'b1;
            case (ir_q[5:0])
                6'b100000: dec_op = OP_ADD;
                6'b100010: dec_op = OP_SUB;
                6'b100100: dec_op = OP_AND;
                6'b100101: dec_op = OP_OR;
                6'b100110: dec_op = OP_XOR;
                6'b100111: dec_op = OP_NOR;
                6'b101011: dec_op = OP_SLTU;
                6'b000100: dec_op = OP_SLLV;
                default:   dec_legal = 1'b0;
            endcase
        end else begin
            dec_legal    = 1'b1;
            dec_rd_rt_s  = 1'b1;
            dec_rt_imm_s = 1'b1;
            case (ir_q[31:26])
                6'b001000: begin dec_op = OP_ADD; dec_imm_s = 1'b1; end
                6'b001100: dec_op = OP_AND;
                6'b001101: dec_op = OP_OR;
                6'b001110: dec_op = OP_XOR;
                default:   dec_legal = 1'b0;
            endcase
        end
    end

    // Next-state logic; an illegal instruction parks the FSM in ID forever
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        rd_rt_s_d  = rd_rt_s_q;
        rt_imm_s_d = rt_imm_s_q;
        imm_s_d    = imm_s_q;
        alu_op_d   = alu_op_q;
        illegal_d  = illegal_q;
        case (state_q)
            S_IF: begin
                ir_d    = Inst_Data;
                pc_d    = pc_q + 32'd4;
                state_d = S_ID;
            end
            S_ID: begin
                if (dec_legal) begin
                    rd_rt_s_d  = dec_rd_rt_s;
                    rt_imm_s_d = dec_rt_imm_s;
                    imm_s_d    = dec_imm_s;
                    alu_op_d   = dec_op;
                    state_d    = S_EX;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            S_EX:    state_d = S_WB;
            default: state_d = S_IF;
        endcase
        write_reg_d = (state_d == S_WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IF;
            pc_q        <= PC_RESET;
            ir_q        <= 32'h0;
            rd_rt_s_q   <= 1'b0;
            rt_imm_s_q  <= 1'b0;
            imm_s_q     <= 1'b0;
            alu_op_q    <= OP_ADD;
            illegal_q   <= 1'b0;
            write_reg_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rd_rt_s_q   <= rd_rt_s_d;
            rt_imm_s_q  <= rt_imm_s_d;
            imm_s_q     <= imm_s_d;
            alu_op_q    <= alu_op_d;
            illegal_q   <= illegal_d;
            write_reg_q <= write_reg_d;
        end
    end

    assign Inst_Addr    = pc_q;
    assign R_Addr_A     = ir_q[25:21];
    assign R_Addr_B     = ir_q[20:16];
    assign W_Addr       = rd_rt_s_q ? ir_q[20:16] : ir_q[15:11];
    assign Imm32        = imm_s_q ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0000, ir_q[15:0]};
    assign Write_Reg    = write_reg_q;
    assign rd_rt_s      = rd_rt_s_q;
    assign rt_imm_s     = rt_imm_s_q;
    assign imm_s        = imm_s_q;
    assign ALU_OP       = alu_op_q;
    assign State        = state_q;
    assign Illegal_Inst = illegal_q;

endmodule

// File: tb/tb_ri_ctrl_unit.sv
// Testbench for ri_ctrl_unit: drives a ROM model, runs directed and random
// instruction streams and compares every stage against a table-driven model.
module tb_ri_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_addr, inst_data, imm32;
    logic [4:0]  r_addr_a, r_addr_b, w_addr;
    logic        write_reg, rd_rt_s, rt_imm_s, imm_s, illegal;
    logic [2:0]  alu_op;
    logic [1:0]  state;

    logic [31:0] w_inst_addr, w_imm32;
    logic [4:0]  w_ra, w_rb, w_wa;
    logic        w_wr, w_rdrt, w_rtimm, w_ims, w_ill;
    logic [2:0]  w_op;
    logic [1:0]  w_state;

    logic [31:0] rom [64];
    logic        noise_en = 1'b0;
    logic [31:0] noise_val = 32'h0;
    logic [31:0] exp_pc;
    int          tests_run = 0;
    int          tests_failed = 0;

    // Instruction tables: mnemonic encoding -> ALU code
    localparam logic [5:0] R_FN [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
    localparam logic [2:0] R_OP [8] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    localparam logic [5:0] I_OC [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
    localparam logic [2:0] I_OP [4] = '{3'd4, 3'd0, 3'd1, 3'd2};
    localparam logic       I_SX [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    assign inst_data = noise_en ? noise_val : rom[inst_addr[7:2]];

    always #5 clk = ~clk;

    ri_ctrl_unit u_dut (
        .clk(clk), .rst(rst), .Inst_Addr(inst_addr), .Inst_Data(inst_data),
        .R_Addr_A(r_addr_a), .R_Addr_B(r_addr_b), .W_Addr(w_addr),
        .Write_Reg(write_reg), .rd_rt_s(rd_rt_s), .rt_imm_s(rt_imm_s),
        .imm_s(imm_s), .Imm32(imm32), .ALU_OP(alu_op), .State(state),
        .Illegal_Inst(illegal)
    );

    ri_ctrl_unit #(.PC_RESET(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst), .Inst_Addr(w_inst_addr), .Inst_Data(32'h0022_1820),
        .R_Addr_A(w_ra), .R_Addr_B(w_rb), .W_Addr(w_wa),
        .Write_Reg(w_wr), .rd_rt_s(w_rdrt), .rt_imm_s(w_rtimm),
        .imm_s(w_ims), .Imm32(w_imm32), .ALU_OP(w_op), .State(w_state),
        .Illegal_Inst(w_ill)
    );

    // Reference decoder: table lookup of legal encodings
    task automatic ref_decode(input logic [31:0] w, output logic lg, output logic [2:0] op,
                              output logic rdrt, output logic rtimm, output logic ims);
        lg = 1'b0; op = 3'd4; rdrt = 1'b0; rtimm = 1'b0; ims = 1'b0;
        if (w[31:26] == 6'd0) begin
            for (int i = 0; i < 8; i++)
                if (w[5:0] == R_FN[i]) begin lg = 1'b1; op = R_OP[i]; end
        end else begin
            for (int i = 0; i < 4; i++)
                if (w[31:26] == I_OC[i]) begin
                    lg = 1'b1; op = I_OP[i]; ims = I_SX[i]; rdrt = 1'b1; rtimm = 1'b1;
                end
        end
    endtask

    function automatic logic [31:0] rand_legal();
        int k;
        k = $urandom_range(0, 11);
        if (k < 8)
            return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), R_FN[k]};
        return {I_OC[k-8], 5'($urandom), 5'($urandom), 16'($urandom)};
    endfunction

    // Holds reset for a cycle, checks the reset image, releases at a falling edge
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({inst_addr, state, write_reg, rd_rt_s, rt_imm_s, imm_s, alu_op, illegal,
             imm32, r_addr_a, r_addr_b, w_addr} !==
            {32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h st=%b wr=%b flags=%b%b%b op=%b ill=%b imm=%h a=%0d b=%0d w=%0d",
                     inst_addr, state, write_reg, rd_rt_s, rt_imm_s, imm_s, alu_op, illegal,
                     imm32, r_addr_a, r_addr_b, w_addr);
        end
        rst = 1'b0;
        exp_pc = 32'h0;
    endtask

    // Runs one legal instruction from exp_pc through all four stages
    task automatic run_instr(input bit noisy);
        logic [31:0] pc, w, imm;
        logic lg, rdrt, rtimm, ims;
        logic [2:0] op;
        logic [4:0] wa;
        pc = exp_pc;
        w  = rom[pc[7:2]];
        ref_decode(w, lg, op, rdrt, rtimm, ims);
        imm = ims ? 32'($signed(w[15:0])) : {16'h0, w[15:0]};
        wa  = rdrt ? w[20:16] : w[15:11];

        tests_run++;
        if ({state, inst_addr, write_reg} !== {2'b00, pc, 1'b0}) begin
            tests_failed++;
            $display("FAIL if_stage: st=%b pc=%h wr=%b exp pc=%h", state, inst_addr, write_reg, pc);
        end
        @(negedge clk);
        if (noisy) begin noise_en = 1'b1; noise_val = $urandom; end
        tests_run++;
        if ({state, inst_addr, write_reg, r_addr_a, r_addr_b, illegal} !==
            {2'b01, pc + 32'd4, 1'b0, w[25:21], w[20:16], 1'b0}) begin
            tests_failed++;
            $display("FAIL id_stage w=%h: st=%b pc=%h wr=%b a=%0d b=%0d ill=%b", w, state,
                     inst_addr, write_reg, r_addr_a, r_addr_b, illegal);
        end
        @(negedge clk);
        if (noisy) noise_val = $urandom;
        tests_run++;
        if ({state, rd_rt_s, rt_imm_s, imm_s, alu_op, imm32, w_addr, write_reg} !==
            {2'b10, rdrt, rtimm, ims, op, imm, wa, 1'b0}) begin
            tests_failed++;
            $display("FAIL ex_stage w=%h: st=%b flags=%b%b%b op=%b imm=%h wa=%0d wr=%b exp flags=%b%b%b op=%b imm=%h wa=%0d",
                     w, state, rd_rt_s, rt_imm_s, imm_s, alu_op, imm32, w_addr, write_reg,
                     rdrt, rtimm, ims, op, imm, wa);
        end
        @(negedge clk);
        tests_run++;
        if ({state, write_reg, w_addr, r_addr_a, r_addr_b, alu_op, rd_rt_s, rt_imm_s, imm_s,
             imm32, illegal, inst_addr} !==
            {2'b11, 1'b1, wa, w[25:21], w[20:16], op, rdrt, rtimm, ims, imm, 1'b0, pc + 32'd4}) begin
            tests_failed++;
            $display("FAIL wb_stage w=%h: st=%b wr=%b wa=%0d op=%b imm=%h ill=%b exp wa=%0d op=%b imm=%h",
                     w, state, write_reg, w_addr, alu_op, imm32, illegal, wa, op, imm);
        end
        noise_en = 1'b0;
        @(negedge clk);
        exp_pc = pc + 32'd4;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_directed();
        rom[0] = 32'h0022_1820;
        rom[1] = 32'h2005_FFFF;
        rom[2] = 32'h3406_8000;
        for (int i = 0; i < 8; i++)
            rom[3+i] = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, R_FN[i]};
        do_reset();
        for (int i = 0; i < 11; i++) run_instr(1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) rom[i] = rand_legal();
        do_reset();
        for (int i = 0; i < 40; i++) run_instr(1'b1);
    endtask

    task automatic test_back_to_back();
        int cnt, first;
        bit overlap, prev;
        for (int i = 0; i < 64; i++) rom[i] = rand_legal();
        do_reset();
        cnt = 0; first = -1; overlap = 1'b0; prev = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (write_reg) begin
                if (first < 0) first = c;
                cnt++;
                if (prev) overlap = 1'b1;
            end
            prev = write_reg;
            @(negedge clk);
        end
        tests_run++;
        if (cnt !== 6 || first !== 3 || overlap) begin
            tests_failed++;
            $display("FAIL back_to_back: pulses=%0d first=%0d overlap=%b exp 6/3/0", cnt, first, overlap);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'hFC00_0000;
        bad[1] = 32'h0022_1821;
        for (int t = 0; t < 2; t++) begin
            rom[0] = bad[t];
            do_reset();
            @(negedge clk);
            @(negedge clk);
            tests_run++;
            if ({state, illegal, inst_addr, write_reg} !== {2'b01, 1'b1, 32'h4, 1'b0}) begin
                tests_failed++;
                $display("FAIL illegal_enter w=%h: st=%b ill=%b pc=%h wr=%b", bad[t], state, illegal,
                         inst_addr, write_reg);
            end
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                tests_run++;
                if ({state, write_reg, inst_addr, illegal} !== {2'b01, 1'b0, 32'h4, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL illegal_hold c=%0d: st=%b wr=%b pc=%h ill=%b", c, state, write_reg,
                             inst_addr, illegal);
                end
            end
            rst = 1'b1;
            #1;
            tests_run++;
            if ({illegal, state, inst_addr} !== {1'b0, 2'b00, 32'h0}) begin
                tests_failed++;
                $display("FAIL illegal_clear: ill=%b st=%b pc=%h", illegal, state, inst_addr);
            end
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic test_reset_in_wb();
        rom[0] = 32'h0022_1820;
        rom[1] = 32'h3406_8000;
        do_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (write_reg !== 1'b1) begin
            tests_failed++;
            $display("FAIL wb_before_rst: wr=%b exp 1", write_reg);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({write_reg, state, inst_addr, illegal} !== {1'b0, 2'b00, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_rst_wb: wr=%b st=%b pc=%h ill=%b", write_reg, state, inst_addr, illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;
        run_instr(1'b0);
        run_instr(1'b0);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        tests_run++;
        if ({w_state, w_inst_addr} !== {2'b00, 32'hFFFF_FFFC}) begin
            tests_failed++;
            $display("FAIL wrap_reset: st=%b pc=%h exp pc=fffffffc", w_state, w_inst_addr);
        end
        @(negedge clk);
        tests_run++;
        if ({w_state, w_inst_addr} !== {2'b01, 32'h0}) begin
            tests_failed++;
            $display("FAIL wrap_after_if: st=%b pc=%h exp pc=00000000", w_state, w_inst_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        exp_pc = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_illegal();
        test_reset_in_wb();
        test_pc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
